// File: rtl/motor_req_sched_if.sv
// Request/data/ack bundle between the three requesters, the scheduler and the
// motor controller (contrl) inputs.
interface motor_req_sched_if #(
  parameter int unsigned DATA_W = 8
);
  logic              geo_req;
  logic [DATA_W-1:0] geo_in;
  logic              gps_req;
  logic [DATA_W-1:0] gps_in;
  logic              qr_req;
  logic              geo_ack;
  logic              gps_ack;
  logic              qr_ack;
  logic              ctl_en;
  logic [DATA_W-1:0] ctl_geo;
  logic [DATA_W-1:0] ctl_gps;
  logic              ctl_qr;
  logic [1:0]        grant;
  logic              busy;

  modport master (
    output geo_req, geo_in, gps_req, gps_in, qr_req,
    input  geo_ack, gps_ack, qr_ack, ctl_en, ctl_geo, ctl_gps, ctl_qr, grant, busy
  );

  modport slave (
    input  geo_req, geo_in, gps_req, gps_in, qr_req,
    output geo_ack, gps_ack, qr_ack, ctl_en, ctl_geo, ctl_gps, ctl_qr, grant, busy
  );
endinterface

// File: rtl/motor_req_sched.sv
// Run/stop scheduler granting one of geo/gps/qr to the shared motor controller.
// Optional macro ROUND_ROBIN_EN: rotating priority instead of fixed qr > geo > gps.
module motor_req_sched #(
  parameter int unsigned RUN_CYCLES = 10,
  parameter int unsigned GAP_CYCLES = 10,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                PWM,
  input  logic                RST,
  input  logic                EN,
  motor_req_sched_if.slave    bus
);

  localparam int unsigned MAX_CYC = (RUN_CYCLES > GAP_CYCLES) ? RUN_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  typedef enum logic [1:0] {GR_NONE, GR_GEO, GR_GPS, GR_QR} grant_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ctl_en_q, ctl_en_d;
  logic [DATA_W-1:0] geo_q, geo_d;
  logic [DATA_W-1:0] gps_q, gps_d;
  logic              qr_q, qr_d;
  grant_t            grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [2:0]        ack_q, ack_d;
  grant_t            winner;
  logic [2:0]        req_vec;

  assign req_vec = {bus.qr_req, bus.gps_req, bus.geo_req};

  function automatic logic [2:0] ack_of(input grant_t g);
    case (g)
      GR_GEO:  ack_of = 3'b001;
      GR_GPS:  ack_of = 3'b010;
      GR_QR:   ack_of = 3'b100;
      default: ack_of = 3'b000;
    endcase
  endfunction

`ifdef ROUND_ROBIN_EN
  // ptr_q holds the index (0=geo,1=gps,2=qr) that currently has top priority.
  logic [1:0] ptr_q, ptr_d;

  function automatic logic [1:0] next_ptr(input grant_t g);
    case (g)
      GR_GEO:  next_ptr = 2'd1;
      GR_GPS:  next_ptr = 2'd2;
      default: next_ptr = 2'd0;
    endcase
  endfunction

  always_comb begin
    winner = GR_NONE;
    for (int unsigned i = 0; i < 3; i++) begin
      int unsigned idx;
      idx = (ptr_q + i) % 3;
      if (winner == GR_NONE && req_vec[idx[1:0]]) begin
        winner = grant_t'(2'(idx + 1));
      end
    end
  end
`else
  always_comb begin
    if (req_vec[2])      winner = GR_QR;
    else if (req_vec[0]) winner = GR_GEO;
    else if (req_vec[1]) winner = GR_GPS;
    else                 winner = GR_NONE;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctl_en_d = 1'b0;
    geo_d    = '0;
    gps_d    = '0;
    qr_d     = 1'b0;
    grant_d  = GR_NONE;
    busy_d   = 1'b0;
    ack_d    = '0;
`ifdef ROUND_ROBIN_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (EN && winner != GR_NONE) begin
          state_d  = RUN;
          cnt_d    = RUN_LOAD;
          ctl_en_d = 1'b1;
          grant_d  = winner;
          busy_d   = 1'b1;
          case (winner)
            GR_GEO:  geo_d = bus.geo_in;
            GR_GPS:  gps_d = bus.gps_in;
            GR_QR:   qr_d  = 1'b1;
            default: ;
          endcase
          if (RUN_CYCLES == 1) begin
            ack_d = ack_of(winner);
`ifdef ROUND_ROBIN_EN
            ptr_d = next_ptr(winner);
`endif
          end
        end
      end
      RUN: begin
        // Ack is registered one cycle ahead so it coincides with the last run
        // cycle; cnt_q==0 therefore means the run already completed.
        if (cnt_q == '0 || !EN) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d    = cnt_q - 1'b1;
          ctl_en_d = 1'b1;
          grant_d  = grant_q;
          geo_d    = geo_q;
          gps_d    = gps_q;
          qr_d     = qr_q;
          busy_d   = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            ack_d = ack_of(grant_q);
`ifdef ROUND_ROBIN_EN
            ptr_d = next_ptr(grant_q);
`endif
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PWM) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ctl_en_q <= 1'b0;
      geo_q    <= '0;
      gps_q    <= '0;
      qr_q     <= 1'b0;
      grant_q  <= GR_NONE;
      busy_q   <= 1'b0;
      ack_q    <= '0;
`ifdef ROUND_ROBIN_EN
      ptr_q    <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctl_en_q <= ctl_en_d;
      geo_q    <= geo_d;
      gps_q    <= gps_d;
      qr_q     <= qr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
`ifdef ROUND_ROBIN_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign bus.ctl_en  = ctl_en_q;
  assign bus.ctl_geo = geo_q;
  assign bus.ctl_gps = gps_q;
  assign bus.ctl_qr  = qr_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.geo_ack = ack_q[0];
  assign bus.gps_ack = ack_q[1];
  assign bus.qr_ack  = ack_q[2];

endmodule

// File: tb/tb_motor_req_sched.sv
// Directed self-checking bench for motor_req_sched; inputs change and outputs
// are sampled on the falling clock edge.
module tb_motor_req_sched;

  localparam int unsigned RUN = 10;
  localparam int unsigned GAP = 10;
  localparam int unsigned DW  = 8;

  logic PWM = 1'b0;
  logic RST;
  logic EN;
  int   checks = 0;
  int   errors = 0;

  motor_req_sched_if #(.DATA_W(DW)) bus ();

  motor_req_sched #(
    .RUN_CYCLES(RUN),
    .GAP_CYCLES(GAP),
    .DATA_W    (DW)
  ) dut (
    .PWM(PWM),
    .RST(RST),
    .EN (EN),
    .bus(bus)
  );

  always #5 PWM = ~PWM;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge PWM);
  endtask

  task automatic drop_req(input logic [1:0] g);
    case (g)
      2'd1:    bus.geo_req = 1'b0;
      2'd2:    bus.gps_req = 1'b0;
      2'd3:    bus.qr_req  = 1'b0;
      default: ;
    endcase
  endtask

  // Entered on run cycle 1; returns on gap cycle 1. At cycle chg_at the
  // input words change and the granted requester drops its req early.
  task automatic run_window(input string tag, input logic [1:0] g, input logic [7:0] gv,
                            input logic [7:0] pv, input logic q, input int unsigned chg_at);
    for (int unsigned i = 1; i <= RUN; i++) begin
      logic [2:0] ack_exp;
      ack_exp = (i == RUN) ? (3'b001 << (g - 2'd1)) : 3'b000;
      check($sformatf("%s.en c%0d", tag, i), bus.ctl_en, 1);
      check($sformatf("%s.grant c%0d", tag, i), bus.grant, g);
      check($sformatf("%s.geo c%0d", tag, i), bus.ctl_geo, gv);
      check($sformatf("%s.gps c%0d", tag, i), bus.ctl_gps, pv);
      check($sformatf("%s.qr c%0d", tag, i), bus.ctl_qr, q);
      check($sformatf("%s.busy c%0d", tag, i), bus.busy, 1);
      check($sformatf("%s.ack c%0d", tag, i), {bus.qr_ack, bus.gps_ack, bus.geo_ack}, ack_exp);
      if (i == chg_at) begin
        bus.geo_in = 8'hC6;
        bus.gps_in = 8'hC6;
        drop_req(g);
      end
      if (i == RUN) drop_req(g);
      tick();
    end
  endtask

  task automatic gap_window(input string tag);
    for (int unsigned i = 1; i <= GAP; i++) begin
      check($sformatf("%s.gap_en c%0d", tag, i), bus.ctl_en, 0);
      check($sformatf("%s.gap_busy c%0d", tag, i), bus.busy, 1);
      check($sformatf("%s.gap_grant c%0d", tag, i), bus.grant, 0);
      check($sformatf("%s.gap_data c%0d", tag, i), {bus.ctl_geo, bus.ctl_gps, 7'd0, bus.ctl_qr}, 0);
      check($sformatf("%s.gap_ack c%0d", tag, i), {bus.qr_ack, bus.gps_ack, bus.geo_ack}, 0);
      tick();
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, ".idle_busy"}, bus.busy, 0);
    check({tag, ".idle_grant"}, bus.grant, 0);
    check({tag, ".idle_en"}, bus.ctl_en, 0);
  endtask

  logic [1:0] order [3];

  initial begin
`ifdef ROUND_ROBIN_EN
    order = '{2'd1, 2'd2, 2'd3};
`else
    order = '{2'd3, 2'd1, 2'd2};
`endif
    RST = 1'b1;
    EN  = 1'b1;
    bus.geo_req = 1'b1;
    bus.gps_req = 1'b1;
    bus.qr_req  = 1'b1;
    bus.geo_in  = 8'h46;
    bus.gps_in  = 8'h46;

    // Reset hold with every request asserted
    repeat (10) tick();
    check("rst.en", bus.ctl_en, 0);
    check("rst.geo", bus.ctl_geo, 0);
    check("rst.gps", bus.ctl_gps, 0);
    check("rst.qr", bus.ctl_qr, 0);
    check("rst.grant", bus.grant, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.ack", {bus.qr_ack, bus.gps_ack, bus.geo_ack}, 0);
    bus.geo_req = 1'b0;
    bus.gps_req = 1'b0;
    bus.qr_req  = 1'b0;
    RST = 1'b0;
    tick();
    idle_check("post_rst");

    // Single geo run, one-cycle latency
    bus.geo_in  = 8'h46;
    bus.geo_req = 1'b1;
    tick();
    run_window("geo", 2'd1, 8'h46, 8'h00, 1'b0, 0);
    gap_window("geo");
    idle_check("geo");

    // Simultaneous requests, starting from a fresh reset
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.geo_in  = 8'hC6;
    bus.gps_in  = 8'hC6;
    bus.geo_req = 1'b1;
    bus.gps_req = 1'b1;
    bus.qr_req  = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      logic [1:0] g;
      g = order[k];
      run_window($sformatf("prio%0d", k), g, (g == 2'd1) ? 8'hC6 : 8'h00,
                 (g == 2'd2) ? 8'hC6 : 8'h00, g == 2'd3, 0);
      gap_window($sformatf("prio%0d", k));
      idle_check($sformatf("prio%0d", k));
      tick();
    end
    idle_check("prio_done");

    // Abort: EN drops on cycle 4 of a gps run
    bus.gps_in  = 8'h46;
    bus.gps_req = 1'b1;
    tick();
    for (int unsigned i = 1; i <= 4; i++) begin
      check($sformatf("abort.en c%0d", i), bus.ctl_en, 1);
      check($sformatf("abort.grant c%0d", i), bus.grant, 2);
      check($sformatf("abort.gps c%0d", i), bus.ctl_gps, 8'h46);
      check($sformatf("abort.ack c%0d", i), {bus.qr_ack, bus.gps_ack, bus.geo_ack}, 0);
      if (i == 4) EN = 1'b0;
      tick();
    end
    gap_window("abort");
    for (int unsigned i = 0; i < 3; i++) begin
      idle_check($sformatf("abort_en0_%0d", i));
      tick();
    end
    EN = 1'b1;
    tick();
    run_window("abort_retry", 2'd2, 8'h00, 8'h46, 1'b0, 0);
    gap_window("abort_retry");
    idle_check("abort_retry");

    // Data captured at grant; req dropped mid-run still completes with ack
    bus.geo_in  = 8'h46;
    bus.geo_req = 1'b1;
    tick();
    run_window("capture", 2'd1, 8'h46, 8'h00, 1'b0, 3);
    gap_window("capture");
    idle_check("capture");

    // Zero word is still a valid grant
    bus.gps_in  = 8'h00;
    bus.gps_req = 1'b1;
    tick();
    run_window("zero", 2'd2, 8'h00, 8'h00, 1'b0, 0);
    gap_window("zero");
    idle_check("zero");

    // Reset on cycle 5 of a qr run
    bus.qr_req = 1'b1;
    tick();
    for (int unsigned i = 1; i <= 5; i++) begin
      check($sformatf("rstrun.qr c%0d", i), bus.ctl_qr, 1);
      check($sformatf("rstrun.ack c%0d", i), bus.qr_ack, 0);
      if (i == 5) RST = 1'b1;
      tick();
    end
    check("rstrun.en", bus.ctl_en, 0);
    check("rstrun.qr", bus.ctl_qr, 0);
    check("rstrun.grant", bus.grant, 0);
    check("rstrun.busy", bus.busy, 0);
    check("rstrun.ack", {bus.qr_ack, bus.gps_ack, bus.geo_ack}, 0);
    RST = 1'b0;
    tick();
    run_window("rstrun_regrant", 2'd3, 8'h00, 8'h00, 1'b1, 0);
    gap_window("rstrun_regrant");
    idle_check("rstrun_regrant");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
